// File: rtl/alu_pkg.sv
// Shared constants for the two-requester ALU arbiter: opcode encoding, FSM state
// encoding and default datapath sizes.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_OPW   = 3;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_SUB  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: logic ops, wrapping ADD/SUB, signed SLT and PASS A,
// plus unsigned carry (NOT borrow for SUB) and signed overflow.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OPW   = ALU_OPW
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           slt;

    assign sum  = {1'b0, a} + {1'b0, b};
    // a + ~b + 1: the extra top bit is the NOT-borrow carry
    assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign slt  = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_ADD: begin
                result = sum[WIDTH-1:0];
                carry  = sum[WIDTH];
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff[WIDTH-1:0];
                carry  = diff[WIDTH];
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: result = {{(WIDTH-1){1'b0}}, slt};
            OP_NOR: result = ~(a | b);
            default: result = a;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FLAGS_EN to add registered rsp_zero/rsp_carry/rsp_ovf outputs.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned OPW   = ALU_OPW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef ALU_ARB_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_ovf,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data
);

    logic [1:0]       state_q, state_d;
    logic             last_grant_q;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q, b_q, data_q;
    logic             id_q;
    logic             idle, gnt, fire;
    logic [WIDTH-1:0] core_result;
    logic             core_carry, core_ovf;

    // Ready is gated by rst_n so nothing can be accepted while reset is held
    assign idle       = rst_n && (state_q == ST_IDLE);
    assign gnt        = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign req0_ready = idle && req0_valid && !gnt;
    assign req1_ready = idle && req1_valid && gnt;
    assign fire       = req0_ready || req1_ready;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (fire) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (core_result),
        .carry  (core_carry),
        .ovf    (core_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                op_q <= gnt ? req1_op : req0_op;
                a_q  <= gnt ? req1_a : req0_a;
                b_q  <= gnt ? req1_b : req0_b;
                id_q <= gnt;
            end
            if (state_q == ST_EXEC) data_q <= core_result;
            if ((state_q == ST_RESP) && rsp_ready) last_grant_q <= id_q;
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    logic zero_q, carry_q, ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            zero_q  <= (core_result == '0);
            carry_q <= core_carry;
            ovf_q   <= core_ovf;
        end
    end

    assign rsp_zero  = zero_q;
    assign rsp_carry = carry_q;
    assign rsp_ovf   = ovf_q;
`else
    logic unused_flags;
    assign unused_flags = core_carry ^ core_ovf;
`endif

endmodule
